// File: rtl/subframe_unpack.sv
// Serial subframe unpacker: AUX/DATA/V/U/C/P parsing with even-parity check and
// per-channel channel-status CRC-8 verification. Define SUBFRAME_UNPACK_ERRCNT_EN to enable parity_err_cnt.
module subframe_unpack #(
    parameter int AUX_W     = 4,
    parameter int DATA_W    = 20,
    parameter int BLOCK_LEN = 192,
    parameter int CHANNELS  = 2,
    parameter int FI_W      = $clog2(BLOCK_LEN),
    parameter int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sync,
    input  logic                 vin,
    input  logic                 din,
    input  logic [FI_W-1:0]      frame_idx,
    input  logic [CH_W-1:0]      in_channel,
    output logic [DATA_W-1:0]    dout,
    output logic [AUX_W-1:0]     dauxout,
    output logic                 vout,
    output logic [CH_W-1:0]      out_channel,
    output logic [BLOCK_LEN-1:0] channeldout,
    output logic                 channelvout,
    output logic                 kill,
    output logic                 done,
    output logic [15:0]          parity_err_cnt
);
    localparam int MAX_W = (AUX_W > DATA_W) ? AUX_W : DATA_W;
    localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam int NCH   = 1 << CH_W;

    localparam logic [CNT_W-1:0] AUX_LAST   = CNT_W'(AUX_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [FI_W-1:0]  FI_ZERO    = {FI_W{1'b0}};
    localparam logic [FI_W-1:0]  FI_LAST    = FI_W'(BLOCK_LEN - 1);
    localparam logic [FI_W-1:0]  FI_CRC_END = FI_W'(BLOCK_LEN - 8);
    localparam logic [CH_W:0]    CH_COUNT   = (CH_W + 1)'(CHANNELS);
    localparam logic [CH_W-1:0]  CH_LAST    = CH_W'(CHANNELS - 1);

    typedef enum logic [2:0] {
        ST_AUX    = 3'd0,
        ST_DATA   = 3'd1,
        ST_VALID  = 3'd2,
        ST_USER   = 3'd3,
        ST_CHAN   = 3'd4,
        ST_PARITY = 3'd5
    } state_t;

    state_t               state_r;
    state_t               state_nx_s;
    logic [CNT_W-1:0]     bit_cnt_r;
    logic                 parity_r;
    logic                 invalid_r;
    logic [CH_W-1:0]      ch_r;
    logic [AUX_W-1:0]     aux_sr_r;
    logic [DATA_W-1:0]    data_sr_r;
    logic [7:0]           crc_r    [NCH];
    logic [BLOCK_LEN-1:0] cs_buf_r [NCH];

    logic                 aux_last_s;
    logic                 data_last_s;
    logic                 ch_ok_s;
    logic                 in_ch_ok_s;
    logic                 parity_ok_s;
    logic                 sub_ok_s;
    logic                 last_frame_s;
    logic                 crc_frame_s;
    logic                 crc_match_s;
    logic [7:0]           crc_cur_s;
    logic [7:0]           crc_nx_s;
    logic [BLOCK_LEN-1:0] cs_buf_nx_s;

    // One MSB-first step of CRC-8, polynomial x^8+x^2+x+1.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
        logic fb;
        fb = crc[7] ^ bit_in;
        return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    // Decode of the current bit against counters, parity and the selected channel's status state.
    always_comb begin
        aux_last_s   = (bit_cnt_r == AUX_LAST);
        data_last_s  = (bit_cnt_r == DATA_LAST);
        ch_ok_s      = ({1'b0, ch_r} < CH_COUNT);
        in_ch_ok_s   = ({1'b0, in_channel} < CH_COUNT);
        parity_ok_s  = (parity_r == din);
        sub_ok_s     = parity_ok_s & ~invalid_r & ch_ok_s;
        last_frame_s = (frame_idx == FI_LAST);
        crc_frame_s  = (frame_idx < FI_CRC_END);
        crc_cur_s    = crc_r[ch_r];
        crc_nx_s     = crc8_step(crc_cur_s, din);
        cs_buf_nx_s  = {cs_buf_r[ch_r][BLOCK_LEN-2:0], din};
        crc_match_s  = (cs_buf_nx_s[7:0] == crc_cur_s);
    end

    // Next-state logic; sync wins over vin and always restarts at AUX.
    always_comb begin
        state_nx_s = state_r;
        if (sync) begin
            state_nx_s = ST_AUX;
        end else if (vin) begin
            case (state_r)
                ST_AUX:    state_nx_s = aux_last_s ? ST_DATA : ST_AUX;
                ST_DATA:   state_nx_s = data_last_s ? ST_VALID : ST_DATA;
                ST_VALID:  state_nx_s = ST_USER;
                ST_USER:   state_nx_s = ST_CHAN;
                ST_CHAN:   state_nx_s = ST_PARITY;
                ST_PARITY: state_nx_s = ST_AUX;
                default:   state_nx_s = ST_AUX;
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_AUX;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Datapath, channel-status tracking and registered output pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_r   <= CNT_ZERO;
            parity_r    <= 1'b0;
            invalid_r   <= 1'b0;
            ch_r        <= {CH_W{1'b0}};
            aux_sr_r    <= {AUX_W{1'b0}};
            data_sr_r   <= {DATA_W{1'b0}};
            dout        <= {DATA_W{1'b0}};
            dauxout     <= {AUX_W{1'b0}};
            out_channel <= {CH_W{1'b0}};
            channeldout <= {BLOCK_LEN{1'b0}};
            vout        <= 1'b0;
            channelvout <= 1'b0;
            kill        <= 1'b0;
            done        <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                crc_r[i]    <= 8'h00;
                cs_buf_r[i] <= {BLOCK_LEN{1'b0}};
            end
        end else begin
            vout        <= 1'b0;
            channelvout <= 1'b0;
            kill        <= 1'b0;
            done        <= 1'b0;
            if (sync) begin
                // Abort: the partial subframe is dropped, channel-status state is kept.
                bit_cnt_r <= CNT_ZERO;
                parity_r  <= 1'b0;
            end else if (vin) begin
                case (state_r)
                    ST_AUX: begin
                        aux_sr_r  <= (aux_sr_r << 1) | AUX_W'(din);
                        bit_cnt_r <= aux_last_s ? CNT_ZERO : (bit_cnt_r + CNT_ONE);
                        if (bit_cnt_r == CNT_ZERO) begin
                            ch_r      <= in_channel;
                            parity_r  <= din;
                            invalid_r <= 1'b0;
                            if ((frame_idx == FI_ZERO) && in_ch_ok_s) begin
                                crc_r[in_channel]    <= 8'h00;
                                cs_buf_r[in_channel] <= {BLOCK_LEN{1'b0}};
                            end
                        end else begin
                            parity_r <= parity_r ^ din;
                        end
                    end
                    ST_DATA: begin
                        data_sr_r <= (data_sr_r << 1) | DATA_W'(din);
                        bit_cnt_r <= data_last_s ? CNT_ZERO : (bit_cnt_r + CNT_ONE);
                        parity_r  <= parity_r ^ din;
                    end
                    ST_VALID: begin
                        invalid_r <= din;
                        parity_r  <= parity_r ^ din;
                    end
                    ST_USER: begin
                        parity_r <= parity_r ^ din;
                    end
                    ST_CHAN: begin
                        parity_r <= parity_r ^ din;
                        // The last 8 C bits of a block carry the CRC, so they only enter the buffer.
                        if (ch_ok_s) begin
                            cs_buf_r[ch_r] <= cs_buf_nx_s;
                            if (crc_frame_s) begin
                                crc_r[ch_r] <= crc_nx_s;
                            end
                            if (last_frame_s) begin
                                if (crc_match_s) begin
                                    channelvout <= 1'b1;
                                    channeldout <= cs_buf_nx_s;
                                    out_channel <= ch_r;
                                end else begin
                                    kill <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_PARITY: begin
                        bit_cnt_r <= CNT_ZERO;
                        parity_r  <= 1'b0;
                        if (sub_ok_s) begin
                            vout        <= 1'b1;
                            dout        <= data_sr_r;
                            dauxout     <= aux_sr_r;
                            out_channel <= ch_r;
                        end
                        if (last_frame_s && (ch_r == CH_LAST)) begin
                            done <= 1'b1;
                        end
                    end
                    default: begin
                        bit_cnt_r <= CNT_ZERO;
                        parity_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef SUBFRAME_UNPACK_ERRCNT_EN
    logic        p_bit_s;
    logic [15:0] err_cnt_r;

    assign p_bit_s = vin & ~sync & (state_r == ST_PARITY);

    // Saturating count of rejected subframes.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_r <= 16'h0000;
        end else if (p_bit_s && !sub_ok_s && (err_cnt_r != 16'hFFFF)) begin
            err_cnt_r <= err_cnt_r + 16'h0001;
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign parity_err_cnt = err_cnt_r;
`else
    assign parity_err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_subframe_unpack.sv
// Scoreboard bench for subframe_unpack: default build plus a second instance with
// AUX_W=6, DATA_W=24, BLOCK_LEN=32, CHANNELS=4.
module tb_subframe_unpack;
    localparam int AW0 = 4, DW0 = 20, BL0 = 192, CN0 = 2;
    localparam int AW1 = 6, DW1 = 24, BL1 = 32,  CN1 = 4;

    typedef struct {
        int           sel;
        int           cyc;
        logic [255:0] val;
        logic [31:0]  aux;
        int           ch;
    } ev_t;

    ev_t vq[$];
    ev_t cq[$];
    ev_t kq[$];
    ev_t dq[$];

    int           n_vec = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           err_exp [2];
    logic [255:0] exp_cd  [2];

    logic clk = 1'b0;
    logic rst, sync;
    logic vin0, din0, vin1, din1;
    logic [7:0] fi0;
    logic [0:0] ic0;
    logic [4:0] fi1;
    logic [1:0] ic1;

    logic [DW0-1:0] dout0;
    logic [AW0-1:0] daux0;
    logic           vout0, channelvout0, kill0, done0;
    logic [0:0]     och0;
    logic [BL0-1:0] chd0;
    logic [15:0]    perr0;
    logic [DW1-1:0] dout1;
    logic [AW1-1:0] daux1;
    logic           vout1, channelvout1, kill1, done1;
    logic [1:0]     och1;
    logic [BL1-1:0] chd1;
    logic [15:0]    perr1;

    subframe_unpack dut0 (
        .clk(clk), .rst(rst), .sync(sync), .vin(vin0), .din(din0),
        .frame_idx(fi0), .in_channel(ic0),
        .dout(dout0), .dauxout(daux0), .vout(vout0), .out_channel(och0),
        .channeldout(chd0), .channelvout(channelvout0), .kill(kill0), .done(done0),
        .parity_err_cnt(perr0)
    );

    subframe_unpack #(.AUX_W(AW1), .DATA_W(DW1), .BLOCK_LEN(BL1), .CHANNELS(CN1)) dut1 (
        .clk(clk), .rst(rst), .sync(sync), .vin(vin1), .din(din1),
        .frame_idx(fi1), .in_channel(ic1),
        .dout(dout1), .dauxout(daux1), .vout(vout1), .out_channel(och1),
        .channeldout(chd1), .channelvout(channelvout1), .kill(kill1), .done(done1),
        .parity_err_cnt(perr1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic int err_model(input int s);
`ifdef SUBFRAME_UNPACK_ERRCNT_EN
        return err_exp[s];
`else
        return 0;
`endif
    endfunction

    function automatic logic [7:0] ref_crc(input logic [255:0] v, input int bl);
        logic [7:0] r;
        r = 8'h00;
        for (int i = bl - 1; i >= 8; i--) begin
            r = (r << 1) ^ (((r[7] ^ v[i]) == 1'b1) ? 8'h07 : 8'h00);
        end
        return r;
    endfunction

    task automatic mon(input int s, input logic vo, input logic [255:0] d, input logic [31:0] a,
                       input int och, input logic cvo, input logic [255:0] cd,
                       input logic kl, input logic dn);
        ev_t e;
        if (vo) begin
            if (vq.size() == 0) check_val("vout_unexpected", 256'(vo), 256'(0));
            else begin
                e = vq.pop_front();
                check_val("vout_inst", 256'(s), 256'(e.sel));
                check_val("vout_cycle", 256'(cyc), 256'(e.cyc));
                check_val("dout", d, e.val);
                check_val("dauxout", 256'(a), 256'(e.aux));
                check_val("out_channel", 256'(och), 256'(e.ch));
            end
        end
        if (cvo) begin
            if (cq.size() == 0) check_val("channelvout_unexpected", 256'(cvo), 256'(0));
            else begin
                e = cq.pop_front();
                check_val("channelvout_inst", 256'(s), 256'(e.sel));
                check_val("channelvout_cycle", 256'(cyc), 256'(e.cyc));
                check_val("channeldout", cd, e.val);
                check_val("cs_out_channel", 256'(och), 256'(e.ch));
            end
        end
        if (kl) begin
            if (kq.size() == 0) check_val("kill_unexpected", 256'(kl), 256'(0));
            else begin
                e = kq.pop_front();
                check_val("kill_inst", 256'(s), 256'(e.sel));
                check_val("kill_cycle", 256'(cyc), 256'(e.cyc));
            end
        end
        if (dn) begin
            if (dq.size() == 0) check_val("done_unexpected", 256'(dn), 256'(0));
            else begin
                e = dq.pop_front();
                check_val("done_inst", 256'(s), 256'(e.sel));
                check_val("done_cycle", 256'(cyc), 256'(e.cyc));
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, vout0, 256'(dout0), 32'(daux0), int'(och0), channelvout0, 256'(chd0), kill0, done0);
        mon(1, vout1, 256'(dout1), 32'(daux1), int'(och1), channelvout1, 256'(chd1), kill1, done1);
    end

    task automatic set_in(input int sel, input logic v, input logic d);
        if (sel == 0) begin
            vin0 = v;
            din0 = d;
        end else begin
            vin1 = v;
            din1 = d;
        end
    endtask

    // cs_ev: 0 none, 1 expect channelvout with cs_val, 2 expect kill (at the C bit).
    task automatic send_subframe(input int sel, input int ch, input int fi, input logic [31:0] aux,
                                 input logic [31:0] data, input logic v, input logic pflip,
                                 input logic c, input int cs_ev, input logic [255:0] cs_val,
                                 input int max_gap, input int abort_at, input logic abort_rst);
        int aw, dw, bl, chn, g;
        logic [31:0] aux_m, data_m;
        logic par;
        logic bq[$];
        ev_t e;
        aw  = (sel == 0) ? AW0 : AW1;
        dw  = (sel == 0) ? DW0 : DW1;
        bl  = (sel == 0) ? BL0 : BL1;
        chn = (sel == 0) ? CN0 : CN1;
        aux_m  = aux & ((32'd1 << aw) - 32'd1);
        data_m = data & ((32'd1 << dw) - 32'd1);
        for (int i = aw - 1; i >= 0; i--) bq.push_back(aux_m[i]);
        for (int i = dw - 1; i >= 0; i--) bq.push_back(data_m[i]);
        bq.push_back(v);
        bq.push_back(1'b0);
        bq.push_back(c);
        par = (^aux_m) ^ (^data_m) ^ v ^ c;
        bq.push_back(par ^ pflip);
        if (sel == 0) begin
            fi0 = 8'(fi);
            ic0 = 1'(ch);
        end else begin
            fi1 = 5'(fi);
            ic1 = 2'(ch);
        end
        for (int k = 0; k < bq.size(); k++) begin
            g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (g) begin
                @(posedge clk);
                #1;
            end
            if (k == abort_at) begin
                if (abort_rst) begin
                    rst = 1'b1;
                    repeat (2) @(posedge clk);
                    #1;
                    rst = 1'b0;
                    err_exp[0] = 0;
                    err_exp[1] = 0;
                    exp_cd[0]  = '0;
                    exp_cd[1]  = '0;
                end else begin
                    sync = 1'b1;
                    set_in(sel, 1'b1, 1'b1);
                    @(posedge clk);
                    #1;
                    sync = 1'b0;
                    set_in(sel, 1'b0, 1'b0);
                end
                return;
            end
            set_in(sel, 1'b1, bq[k]);
            e.sel = sel;
            e.cyc = cyc + 1;
            e.val = '0;
            e.aux = '0;
            e.ch  = ch;
            if (k == aw + dw + 2) begin
                if (cs_ev == 1) begin
                    e.val = cs_val;
                    cq.push_back(e);
                    exp_cd[sel] = cs_val;
                end else if (cs_ev == 2) begin
                    kq.push_back(e);
                end
            end
            if (k == aw + dw + 3) begin
                if (!pflip && !v && ch < chn) begin
                    e.val = 256'(data_m);
                    e.aux = aux_m;
                    vq.push_back(e);
                end else begin
                    err_exp[sel]++;
                end
                if (fi == bl - 1 && ch == chn - 1) dq.push_back(e);
            end
            @(posedge clk);
            #1;
            set_in(sel, 1'b0, 1'b0);
        end
    endtask

    // stop_fi >= 0: reset arrives mid-subframe of channel 1 at that frame.
    task automatic send_block(input int sel, input int nch, input int bad_ch, input int stop_fi);
        int bl, ev;
        logic [255:0] cs [4];
        bl = (sel == 0) ? BL0 : BL1;
        for (int c = 0; c < nch; c++) begin
            cs[c] = '0;
            for (int i = bl - 1; i >= 8; i--) cs[c][i] = 1'($urandom_range(1, 0));
            cs[c][7:0] = ref_crc(cs[c], bl);
            if (c == bad_ch) cs[c][3] = ~cs[c][3];
        end
        for (int fi = 0; fi < bl; fi++) begin
            for (int c = 0; c < nch; c++) begin
                ev = (fi == bl - 1) ? ((c == bad_ch) ? 2 : 1) : 0;
                if (fi == stop_fi && c == 1) begin
                    send_subframe(sel, c, fi, $urandom, $urandom, 1'b0, 1'b0, cs[c][bl-1-fi],
                                  0, cs[c], 0, 8, 1'b1);
                    return;
                end
                send_subframe(sel, c, fi, $urandom, $urandom, 1'b0, 1'b0, cs[c][bl-1-fi],
                              ev, cs[c], 0, -1, 1'b0);
            end
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        err_exp[0] = 0;
        err_exp[1] = 0;
        exp_cd[0]  = '0;
        exp_cd[1]  = '0;
        rst = 1'b1; sync = 1'b0;
        vin0 = 1'b0; din0 = 1'b0; vin1 = 1'b0; din1 = 1'b0;
        fi0 = 8'd0; ic0 = 1'b0; fi1 = 5'd0; ic1 = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check_val("rst_dout0", 256'(dout0), 256'(0));
        check_val("rst_daux0", 256'(daux0), 256'(0));
        check_val("rst_och0", 256'(och0), 256'(0));
        check_val("rst_chd0", 256'(chd0), 256'(0));
        check_val("rst_perr0", 256'(perr0), 256'(0));
        check_val("rst_pulses0", 256'({vout0, channelvout0, kill0, done0}), 256'(0));
        check_val("rst_dout1", 256'(dout1), 256'(0));
        check_val("rst_chd1", 256'(chd1), 256'(0));
        check_val("rst_pulses1", 256'({vout1, channelvout1, kill1, done1}), 256'(0));

        // Basic accepted subframe, then parity error and V=1 rejections.
        send_subframe(0, 0, 3, 32'hA, 32'h12345, 1'b0, 1'b0, 1'b0, 0, '0, 0, -1, 1'b0);
        send_subframe(0, 0, 3, 32'hA, 32'h12345, 1'b0, 1'b1, 1'b0, 0, '0, 0, -1, 1'b0);
        send_subframe(0, 1, 3, 32'h3, 32'h54321, 1'b1, 1'b0, 1'b1, 0, '0, 0, -1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_val("perr_after_reject", 256'(perr0), 256'(err_model(0)));
        check_val("dout_hold", 256'(dout0), 256'(32'h12345));
        check_val("daux_hold", 256'(daux0), 256'(32'hA));

        // Same subframe with random vin gaps.
        send_subframe(0, 0, 3, 32'hA, 32'h12345, 1'b0, 1'b0, 1'b0, 0, '0, 3, -1, 1'b0);
        // Sync at DATA bit 10, then a clean subframe.
        send_subframe(0, 1, 4, 32'h6, 32'hFFFFF, 1'b0, 1'b0, 1'b0, 0, '0, 0, AW0 + 10, 1'b0);
        send_subframe(0, 1, 4, 32'h5, 32'h0BEEF, 1'b0, 1'b0, 1'b1, 0, '0, 0, -1, 1'b0);

        send_block(0, 2, -1, -1);
        send_block(0, 2, 1, -1);
        repeat (2) @(posedge clk);
        #1;
        check_val("chd_hold_after_kill", 256'(chd0), exp_cd[0]);

        // Reset mid-block, then a fresh block.
        send_block(0, 2, -1, 10);
        check_val("rst_mid_dout0", 256'(dout0), 256'(0));
        check_val("rst_mid_chd0", 256'(chd0), 256'(0));
        check_val("rst_mid_perr0", 256'(perr0), 256'(0));
        send_block(0, 2, -1, -1);

        // Alternate-parameter instance.
        send_subframe(1, 0, 3, 32'hA, 32'h12345, 1'b0, 1'b0, 1'b0, 0, '0, 0, -1, 1'b0);
        send_subframe(1, 2, 3, 32'h2A, 32'hABCDEF, 1'b0, 1'b0, 1'b1, 0, '0, 2, -1, 1'b0);
        send_block(1, 4, -1, -1);
        send_block(1, 4, 2, -1);

        repeat (5) @(posedge clk);
        #1;
        check_val("vout_pending", 256'(vq.size()), 256'(0));
        check_val("channelvout_pending", 256'(cq.size()), 256'(0));
        check_val("kill_pending", 256'(kq.size()), 256'(0));
        check_val("done_pending", 256'(dq.size()), 256'(0));
        check_val("perr_final0", 256'(perr0), 256'(err_model(0)));
        check_val("perr_final1", 256'(perr1), 256'(err_model(1)));
        check_val("chd_final1", 256'(chd1), exp_cd[1]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
